// File: rtl/cache_bank_pkg.sv
// cache_bank_pkg: shared widths and bank port selector for the cache bank arbiter
package cache_bank_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LINES = 256;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} portSel_t;
endpackage

// File: rtl/cache_bank_arbiter_rr_pick2.sv
// rr_pick2: picks the first two valid requesters scanning upward from rrPtr, wrapping modulo N
module rr_pick2 #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] rrPtr,
    output logic [IW-1:0] w0,
    output logic [IW-1:0] w1,
    output logic          found0,
    output logic          found1
);
    always_comb begin
        w0 = '0;
        w1 = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(rrPtr) + k;
            if (idx >= N) idx = idx - N;
            if (valid[idx] && !found0) begin
                found0 = 1'b1;
                w0 = IW'(idx);
            end else if (valid[idx] && !found1) begin
                found1 = 1'b1;
                w1 = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/cache_bank_arbiter.sv
// cache_bank_arbiter: grants up to two requesters per cycle onto a dual-port bank,
// blocks same-address write hazards and tracks which lines have been written.
module cache_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = cache_bank_pkg::ADDR_W,
    parameter int DATA_W = cache_bank_pkg::DATA_W,
    parameter int LINES = cache_bank_pkg::LINES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic [NUM_REQ-1:0]        rsp_written,
    input  logic                      inv_all,
    output logic [ADDR_W-1:0]         bank_addr_A,
    output logic [DATA_W-1:0]         bank_din_A,
    output logic                      bank_wen_A,
    input  logic [DATA_W-1:0]         bank_dout_A,
    output logic [ADDR_W-1:0]         bank_addr_B,
    output logic [DATA_W-1:0]         bank_din_B,
    output logic                      bank_wen_B,
    input  logic [DATA_W-1:0]         bank_dout_B
);
    import cache_bank_pkg::*;
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0] rrPtr, nextPtr, lastGrant, w0, w1;
    logic found0, found1, grantA, grantB, wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1, holdAddrA, holdAddrB;
    logic [DATA_W-1:0] din0, din1, holdDinA, holdDinB;
    logic [LINES-1:0] written, wrNext;
    logic [NUM_REQ-1:0] rspPend, rspWr, rdWr, rdOnB;
    portSel_t rspPort [NUM_REQ];

    rr_pick2 #(.N(NUM_REQ)) picker (
        .valid(req_valid),
        .rrPtr(rrPtr),
        .w0(w0),
        .w1(w1),
        .found0(found0),
        .found1(found1)
    );

    // A second winner touching the same line as the first, with any write involved, retries
    always_comb begin
        addr0 = req_addr[w0*ADDR_W +: ADDR_W];
        addr1 = req_addr[w1*ADDR_W +: ADDR_W];
        din0 = req_wdata[w0*DATA_W +: DATA_W];
        din1 = req_wdata[w1*DATA_W +: DATA_W];
        wr0 = req_write[w0];
        wr1 = req_write[w1];
        grantA = found0 && !reset;
        grantB = found1 && !reset && !(addr0 == addr1 && (wr0 || wr1));
        lastGrant = grantB ? w1 : w0;
        nextPtr = (lastGrant == PW'(NUM_REQ - 1)) ? '0 : lastGrant + 1'b1;
        bank_addr_A = grantA ? addr0 : holdAddrA;
        bank_din_A = grantA ? din0 : holdDinA;
        bank_wen_A = !(grantA && wr0);
        bank_addr_B = grantB ? addr1 : holdAddrB;
        bank_din_B = grantB ? din1 : holdDinB;
        bank_wen_B = !(grantB && wr1);
    end

    always_comb begin
        req_grant = '0;
        rdWr = '0;
        rdOnB = '0;
        wrNext = inv_all ? '0 : written;
        if (grantA) begin
            req_grant[w0] = 1'b1;
            rdWr[w0] = written[addr0];
            if (wr0) wrNext[addr0] = 1'b1;
        end
        if (grantB) begin
            req_grant[w1] = 1'b1;
            rdWr[w1] = written[addr1];
            rdOnB[w1] = 1'b1;
            if (wr1) wrNext[addr1] = 1'b1;
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_data[i*DATA_W +: DATA_W] = !rspPend[i] ? '0 : (rspPort[i] == PORT_B) ? bank_dout_B : bank_dout_A;
        rsp_valid = rspPend;
        rsp_written = rspWr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr <= '0;
            written <= '0;
            holdAddrA <= '0;
            holdAddrB <= '0;
            holdDinA <= '0;
            holdDinB <= '0;
            rspPend <= '0;
            rspWr <= '0;
            for (int i = 0; i < NUM_REQ; i++) rspPort[i] <= PORT_A;
        end else begin
            if (grantA) rrPtr <= nextPtr;
            written <= wrNext;
            holdAddrA <= bank_addr_A;
            holdAddrB <= bank_addr_B;
            holdDinA <= bank_din_A;
            holdDinB <= bank_din_B;
            rspPend <= req_grant & ~req_write;
            rspWr <= rdWr & req_grant & ~req_write;
            for (int i = 0; i < NUM_REQ; i++) rspPort[i] <= rdOnB[i] ? PORT_B : PORT_A;
        end
    end
endmodule

// File: tb/tb_cache_bank_arbiter.sv
// tb_cache_bank_arbiter: scoreboard bench with a behavioural dual-port bank
module tb_cache_bank_arbiter;
    localparam int N = 4, AW = 8, DW = 32;
    typedef struct {int idx; logic [DW-1:0] data; logic wr;} rsp_t;

    logic clk = 1'b0, reset = 1'b1, inv_all = 1'b0;
    logic [N-1:0] req_valid = '0, req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0] req_grant, rsp_valid, rsp_written;
    logic [N*DW-1:0] rsp_data;
    logic [AW-1:0] bank_addr_A, bank_addr_B;
    logic [DW-1:0] bank_din_A, bank_din_B, bank_dout_A, bank_dout_B;
    logic bank_wen_A, bank_wen_B;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] expMem [256];
    bit [255:0] expWritten;
    rsp_t sb[$];
    int checks = 0, errors = 0;

    cache_bank_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_written(rsp_written),
        .inv_all(inv_all),
        .bank_addr_A(bank_addr_A), .bank_din_A(bank_din_A), .bank_wen_A(bank_wen_A), .bank_dout_A(bank_dout_A),
        .bank_addr_B(bank_addr_B), .bank_din_B(bank_din_B), .bank_wen_B(bank_wen_B), .bank_dout_B(bank_dout_B)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(int i);
        return 32'hA500_0000 | 32'(i * 32'h0001_0101);
    endfunction

    initial for (int i = 0; i < 256; i++) mem[i] <= pat(i);

    always @(posedge clk) begin
        if (!bank_wen_A) mem[bank_addr_A] <= bank_din_A;
        if (!bank_wen_B) mem[bank_addr_B] <= bank_din_B;
        bank_dout_A <= mem[bank_addr_A];
        bank_dout_B <= mem[bank_addr_B];
    end

    task automatic set_req(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_write = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_grant, rsp_valid, rsp_written} !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b valid=%b written=%b data=%h required zeros", req_grant, rsp_valid, rsp_written, rsp_data);
        end
        checks++;
        if ({bank_wen_A, bank_wen_B} !== 2'b11 || bank_addr_A !== '0 || bank_addr_B !== '0 || bank_din_A !== '0 || bank_din_B !== '0) begin
            errors++;
            $display("FAIL reset_bank got wen=%b%b addr=%h/%h din=%h/%h required wen=11 rest 0", bank_wen_A, bank_wen_B, bank_addr_A, bank_addr_B, bank_din_A, bank_din_B);
        end
        reset = 1'b0;
        expWritten = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bank_wen_A, bank_wen_B} !== 2'b11 || rsp_valid !== '0 || req_grant !== '0) begin
                errors++;
                $display("FAIL idle cycle %0d got wen=%b%b valid=%b grant=%b required wen=11 valid=0 grant=0", c, bank_wen_A, bank_wen_B, rsp_valid, req_grant);
            end
        end
    endtask

    task automatic test_write_read();
        rsp_t e;
        logic [N-1:0] ev;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ev = '0;
            while (sb.size() > 0) begin
                e = sb.pop_front(); ev[e.idx] = 1'b1; checks++;
                if (rsp_data[e.idx*DW +: DW] !== e.data || rsp_written[e.idx] !== e.wr) begin
                    errors++; $display("FAIL wr_rd rsp[%0d] got %h/%b required %h/%b", e.idx, rsp_data[e.idx*DW +: DW], rsp_written[e.idx], e.data, e.wr);
                end
            end
            checks++;
            if (rsp_valid !== ev) begin errors++; $display("FAIL wr_rd rsp_valid got %b required %b", rsp_valid, ev); end
            clr_all();
            if (c == 0) begin
                set_req(0, 1'b1, 8'h10, 32'hDEAD_BEEF); #1;
                checks++;
                if (req_grant !== 4'b0001 || bank_wen_A !== 1'b0 || bank_addr_A !== 8'h10 || bank_din_A !== 32'hDEAD_BEEF || bank_wen_B !== 1'b1) begin
                    errors++; $display("FAIL wr_grant got grant=%b wenA=%b addrA=%h dinA=%h wenB=%b required 0001/0/10/deadbeef/1", req_grant, bank_wen_A, bank_addr_A, bank_din_A, bank_wen_B);
                end
                expMem[8'h10] = 32'hDEAD_BEEF; expWritten[8'h10] = 1'b1;
            end else if (c == 1) begin
                set_req(1, 1'b0, 8'h10, '0); #1;
                checks++;
                if (req_grant !== 4'b0010 || bank_wen_A !== 1'b1 || bank_addr_A !== 8'h10) begin
                    errors++; $display("FAIL rd_grant got grant=%b wenA=%b addrA=%h required 0010/1/10", req_grant, bank_wen_A, bank_addr_A);
                end
                sb.push_back('{idx: 1, data: expMem[8'h10], wr: expWritten[8'h10]});
            end
        end
    endtask

    task automatic test_rr_reads();
        rsp_t e;
        logic [N-1:0] ev;
        int a0;
        @(negedge clk); reset = 1'b1; sb.delete(); expWritten = '0;
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ev = '0;
            while (sb.size() > 0) begin
                e = sb.pop_front(); ev[e.idx] = 1'b1; checks++;
                if (rsp_data[e.idx*DW +: DW] !== e.data || rsp_written[e.idx] !== e.wr) begin
                    errors++; $display("FAIL rr rsp[%0d] got %h/%b required %h/%b", e.idx, rsp_data[e.idx*DW +: DW], rsp_written[e.idx], e.data, e.wr);
                end
            end
            checks++;
            if (rsp_valid !== ev) begin errors++; $display("FAIL rr rsp_valid got %b required %b", rsp_valid, ev); end
            clr_all();
            if (c < 6) begin
                for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h40 + i), '0);
                #1;
                a0 = (c % 2 == 0) ? 0 : 2;
                checks++;
                if (req_grant !== ((c % 2 == 0) ? 4'b0011 : 4'b1100) || bank_addr_A !== 8'(8'h40 + a0) || bank_addr_B !== 8'(8'h41 + a0) || {bank_wen_A, bank_wen_B} !== 2'b11) begin
                    errors++; $display("FAIL rr_grant cycle %0d got grant=%b addr=%h/%h wen=%b%b", c, req_grant, bank_addr_A, bank_addr_B, bank_wen_A, bank_wen_B);
                end
                sb.push_back('{idx: a0, data: expMem[8'(8'h40 + a0)], wr: expWritten[8'(8'h40 + a0)]});
                sb.push_back('{idx: a0 + 1, data: expMem[8'(8'h41 + a0)], wr: expWritten[8'(8'h41 + a0)]});
            end
        end
    endtask

    task automatic test_hazard();
        rsp_t e;
        logic [N-1:0] ev;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ev = '0;
            while (sb.size() > 0) begin
                e = sb.pop_front(); ev[e.idx] = 1'b1; checks++;
                if (rsp_data[e.idx*DW +: DW] !== e.data || rsp_written[e.idx] !== e.wr) begin
                    errors++; $display("FAIL hazard rsp[%0d] got %h/%b required %h/%b", e.idx, rsp_data[e.idx*DW +: DW], rsp_written[e.idx], e.data, e.wr);
                end
            end
            checks++;
            if (rsp_valid !== ev) begin errors++; $display("FAIL hazard rsp_valid got %b required %b", rsp_valid, ev); end
            clr_all();
            if (c == 0) begin
                set_req(0, 1'b1, 8'h20, 32'hCAFE_F00D);
                set_req(1, 1'b0, 8'h20, '0); #1;
                checks++;
                if (req_grant !== 4'b0001 || bank_wen_A !== 1'b0 || bank_wen_B !== 1'b1 || bank_addr_B !== 8'h43) begin
                    errors++; $display("FAIL hazard_block got grant=%b wen=%b%b addrB=%h required 0001 wen=01 addrB=43", req_grant, bank_wen_A, bank_wen_B, bank_addr_B);
                end
                expMem[8'h20] = 32'hCAFE_F00D; expWritten[8'h20] = 1'b1;
            end else if (c == 1) begin
                set_req(1, 1'b0, 8'h20, '0); #1;
                checks++;
                if (req_grant !== 4'b0010 || bank_addr_A !== 8'h20 || bank_wen_A !== 1'b1) begin
                    errors++; $display("FAIL hazard_retry got grant=%b addrA=%h wenA=%b required 0010/20/1", req_grant, bank_addr_A, bank_wen_A);
                end
                sb.push_back('{idx: 1, data: expMem[8'h20], wr: expWritten[8'h20]});
            end
        end
    endtask

    task automatic test_written_inv();
        rsp_t e;
        logic [N-1:0] ev;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ev = '0;
            while (sb.size() > 0) begin
                e = sb.pop_front(); ev[e.idx] = 1'b1; checks++;
                if (rsp_data[e.idx*DW +: DW] !== e.data || rsp_written[e.idx] !== e.wr) begin
                    errors++; $display("FAIL inv rsp[%0d] got %h/%b required %h/%b", e.idx, rsp_data[e.idx*DW +: DW], rsp_written[e.idx], e.data, e.wr);
                end
            end
            checks++;
            if (rsp_valid !== ev) begin errors++; $display("FAIL inv rsp_valid got %b required %b", rsp_valid, ev); end
            clr_all();
            inv_all = 1'b0;
            if (c == 0) begin
                set_req(2, 1'b0, 8'hFF, '0);
                set_req(3, 1'b1, 8'h10, 32'h0BAD_F00D); #1;
                checks++;
                if (req_grant !== 4'b1100 || bank_addr_A !== 8'hFF || bank_wen_A !== 1'b1 || bank_addr_B !== 8'h10 || bank_wen_B !== 1'b0 || bank_din_B !== 32'h0BAD_F00D) begin
                    errors++; $display("FAIL inv_c0 got grant=%b addr=%h/%h wen=%b%b dinB=%h", req_grant, bank_addr_A, bank_addr_B, bank_wen_A, bank_wen_B, bank_din_B);
                end
                sb.push_back('{idx: 2, data: expMem[8'hFF], wr: expWritten[8'hFF]});
                expMem[8'h10] = 32'h0BAD_F00D; expWritten[8'h10] = 1'b1;
            end else if (c == 1) begin
                inv_all = 1'b1;
                set_req(0, 1'b1, 8'h05, 32'h1234_5678);
                set_req(1, 1'b0, 8'h10, '0); #1;
                checks++;
                if (req_grant !== 4'b0011 || bank_addr_A !== 8'h05 || bank_wen_A !== 1'b0 || bank_addr_B !== 8'h10 || bank_wen_B !== 1'b1) begin
                    errors++; $display("FAIL inv_c1 got grant=%b addr=%h/%h wen=%b%b", req_grant, bank_addr_A, bank_addr_B, bank_wen_A, bank_wen_B);
                end
                sb.push_back('{idx: 1, data: expMem[8'h10], wr: expWritten[8'h10]});
                expWritten = '0;
                expMem[8'h05] = 32'h1234_5678; expWritten[8'h05] = 1'b1;
            end else if (c == 2) begin
                set_req(2, 1'b0, 8'h05, '0);
                set_req(3, 1'b0, 8'h10, '0); #1;
                checks++;
                if (req_grant !== 4'b1100) begin
                    errors++; $display("FAIL inv_c2 got grant=%b required 1100", req_grant);
                end
                sb.push_back('{idx: 2, data: expMem[8'h05], wr: expWritten[8'h05]});
                sb.push_back('{idx: 3, data: expMem[8'h10], wr: expWritten[8'h10]});
            end
        end
    endtask

    task automatic test_reset_midflight();
        rsp_t e;
        logic [N-1:0] ev;
        @(negedge clk);
        clr_all();
        set_req(0, 1'b0, 8'h05, '0); #1;
        checks++;
        if (req_grant !== 4'b0001) begin errors++; $display("FAIL mid_grant got %b required 0001", req_grant); end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL mid_pre got rsp_valid=%b required 0001", rsp_valid); end
        reset = 1'b1; #1;
        clr_all(); sb.delete(); expWritten = '0;
        checks++;
        if (rsp_valid !== '0 || rsp_data !== '0) begin errors++; $display("FAIL mid_drop got valid=%b data=%h required 0", rsp_valid, rsp_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ev = '0;
            while (sb.size() > 0) begin
                e = sb.pop_front(); ev[e.idx] = 1'b1; checks++;
                if (rsp_data[e.idx*DW +: DW] !== e.data || rsp_written[e.idx] !== e.wr) begin
                    errors++; $display("FAIL mid rsp[%0d] got %h/%b required %h/%b", e.idx, rsp_data[e.idx*DW +: DW], rsp_written[e.idx], e.data, e.wr);
                end
            end
            checks++;
            if (rsp_valid !== ev) begin errors++; $display("FAIL mid rsp_valid got %b required %b", rsp_valid, ev); end
            clr_all();
            if (c == 0) begin
                set_req(0, 1'b0, 8'h05, '0);
                set_req(1, 1'b0, 8'h10, '0);
                set_req(3, 1'b0, 8'h20, '0); #1;
                checks++;
                if (req_grant !== 4'b0011) begin errors++; $display("FAIL mid_ptr got grant=%b required 0011", req_grant); end
                sb.push_back('{idx: 0, data: expMem[8'h05], wr: expWritten[8'h05]});
                sb.push_back('{idx: 1, data: expMem[8'h10], wr: expWritten[8'h10]});
            end else if (c == 1) begin
                set_req(3, 1'b0, 8'h20, '0); #1;
                checks++;
                if (req_grant !== 4'b1000) begin errors++; $display("FAIL mid_next got grant=%b required 1000", req_grant); end
                sb.push_back('{idx: 3, data: expMem[8'h20], wr: expWritten[8'h20]});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) expMem[i] = pat(i);
        expWritten = '0;
        test_reset();
        test_write_read();
        test_rr_reads();
        test_hazard();
        test_written_inv();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
